// File: rtl/switch_in_port_if.sv
// Bundle of the byte-stream input side, the committed-packet output side,
// the status counters and the FSM debug view of one switch input port.
interface switch_in_port_if #(
   parameter int DEST_W = 2
);
   logic [7:0]        data_in;
   logic              status_in;
   logic              busy;
   logic              out_valid;
   logic              out_ready;
   logic [7:0]        out_data;
   logic [DEST_W-1:0] out_dest;
   logic              out_sop;
   logic              out_eop;
   logic [7:0]        pkt_cnt;
   logic [7:0]        drop_cnt;
   logic [1:0]        fsm_state;

   // Output handshake: a byte moves on a rising edge where out_valid && out_ready;
   // while out_valid=1 and out_ready=0 every out_* field holds its value.
   modport slave (
      input  data_in, status_in, out_ready,
      output busy, out_valid, out_data, out_dest, out_sop, out_eop,
             pkt_cnt, drop_cnt, fsm_state
   );

   modport master (
      output data_in, status_in, out_ready,
      input  busy, out_valid, out_data, out_dest, out_sop, out_eop,
             pkt_cnt, drop_cnt, fsm_state
   );
endinterface

// File: rtl/switch_in_port.sv
// Switch input port: parses header/length/payload bytes into a packet buffer
// and releases a packet to the output only once its last byte is written.
module switch_in_port #(
   parameter int DEPTH  = 16,
   parameter int DEST_W = 2
) (
   input logic            clk,
   input logic            rst,
   switch_in_port_if.slave sw
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int EW = DEST_W + 10;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LEN     = 2'd1,
      PAYLOAD = 2'd2,
      DROP    = 2'd3
   } state_t;

   state_t            state, state_nx;
   logic [EW-1:0]     mem [DEPTH];
   logic [PW-1:0]     wr_ptr, commit_ptr, rd_ptr;
   logic [PW-1:0]     occ;
   logic [8:0]        free_cnt;
   logic [DEST_W-1:0] dest_q;
   logic [7:0]        remaining;
   logic              first_q;
   logic              commit_pend;
   logic [7:0]        pkt_cnt_q, drop_cnt_q;
   logic [EW-1:0]     rd_entry;
   logic              rd_fire;

   logic load_dest, load_len, wr_en, rewind, drop_inc, dec_rem, finish_pkt;

   // Occupancy counts uncommitted bytes too, so a packet is only admitted if it fits.
   assign occ      = wr_ptr - rd_ptr;
   assign free_cnt = 9'(DEPTH) - 9'(occ);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      load_dest  = 1'b0;
      load_len   = 1'b0;
      wr_en      = 1'b0;
      rewind     = 1'b0;
      drop_inc   = 1'b0;
      dec_rem    = 1'b0;
      finish_pkt = 1'b0;
      case (state)
         IDLE: begin
            if (sw.status_in) begin
               load_dest = 1'b1;
               state_nx  = LEN;
            end
         end
         LEN: begin
            if (sw.status_in) begin
               load_dest = 1'b1;
               drop_inc  = 1'b1;
               state_nx  = LEN;
            end else if (sw.data_in == 8'd0 || {1'b0, sw.data_in} > free_cnt) begin
               load_len = 1'b1;
               drop_inc = 1'b1;
               state_nx = (sw.data_in == 8'd0) ? IDLE : DROP;
            end else begin
               load_len = 1'b1;
               state_nx = PAYLOAD;
            end
         end
         PAYLOAD: begin
            if (sw.status_in) begin
               load_dest = 1'b1;
               rewind    = 1'b1;
               drop_inc  = 1'b1;
               state_nx  = LEN;
            end else begin
               wr_en   = 1'b1;
               dec_rem = 1'b1;
               if (remaining == 8'd1) begin
                  finish_pkt = 1'b1;
                  state_nx   = IDLE;
               end
            end
         end
         DROP: begin
            if (sw.status_in) begin
               load_dest = 1'b1;
               state_nx  = LEN;
            end else begin
               dec_rem = 1'b1;
               if (remaining <= 8'd1) state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Buffer storage carries no reset; stale entries are never visible past commit_ptr.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr[AW-1:0]] <= {first_q, (remaining == 8'd1), dest_q, sw.data_in};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         commit_ptr  <= '0;
         rd_ptr      <= '0;
         dest_q      <= '0;
         remaining   <= '0;
         first_q     <= 1'b0;
         commit_pend <= 1'b0;
         pkt_cnt_q   <= '0;
         drop_cnt_q  <= '0;
      end else begin
         if (load_dest) dest_q <= sw.data_in[DEST_W-1:0];
         if (load_len) begin
            remaining <= sw.data_in;
            first_q   <= 1'b1;
         end else if (dec_rem) begin
            remaining <= remaining - 8'd1;
         end
         if (wr_en) begin
            wr_ptr  <= wr_ptr + 1'b1;
            first_q <= 1'b0;
         end
         if (rewind) wr_ptr <= commit_ptr;
         // Commit one edge after the last payload byte is written.
         commit_pend <= finish_pkt;
         if (commit_pend) begin
            commit_ptr <= wr_ptr;
            if (pkt_cnt_q != 8'hFF) pkt_cnt_q <= pkt_cnt_q + 8'd1;
         end
         if (drop_inc && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
         if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   assign rd_entry     = mem[rd_ptr[AW-1:0]];
   assign sw.out_valid = (rd_ptr != commit_ptr);
   assign rd_fire      = sw.out_valid && sw.out_ready;
   assign sw.out_sop   = rd_entry[EW-1];
   assign sw.out_eop   = rd_entry[EW-2];
   assign sw.out_dest  = rd_entry[DEST_W+7:8];
   assign sw.out_data  = rd_entry[7:0];
   assign sw.busy      = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                         (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign sw.pkt_cnt   = pkt_cnt_q;
   assign sw.drop_cnt  = drop_cnt_q;
   assign sw.fsm_state = state;
endmodule

// File: tb/tb_switch_in_port.sv
// Self-checking bench for switch_in_port: packet scenarios driven byte by byte,
// output stream checked in order against a queue of expected entries.
module tb_switch_in_port;
   localparam int DEPTH  = 16;
   localparam int DEST_W = 2;
   localparam int EW     = DEST_W + 10;

   logic clk = 1'b0;
   logic rst = 1'b1;

   switch_in_port_if #(.DEST_W(DEST_W)) sw ();

   switch_in_port #(.DEPTH(DEPTH), .DEST_W(DEST_W)) dut (
      .clk (clk),
      .rst (rst),
      .sw  (sw)
   );

   always #5 clk = ~clk;

   logic [EW-1:0] exp_q[$];
   int            n_checks = 0;
   int            n_fail   = 0;
   int            n_out    = 0;
   bit            rand_ready = 1'b0;

   // Output monitor: scoreboard pop on each transfer, plus hold-stability check.
   logic [EW-1:0] prev_out;
   bit            prev_hold = 1'b0;
   always @(negedge clk) begin
      logic [EW-1:0] cur;
      logic [EW-1:0] exp_v;
      cur = {sw.out_sop, sw.out_eop, sw.out_dest, sw.out_data};
      if (rst) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            n_checks++;
            if (sw.out_valid !== 1'b1 || cur !== prev_out) begin
               n_fail++;
               $display("FAIL hold_stable: got valid=%b out=%h, required valid=1 out=%h",
                        sw.out_valid, cur, prev_out);
            end
         end
         if (sw.out_valid === 1'b1 && sw.out_ready === 1'b1) begin
            n_checks++;
            n_out++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_out: got %h, required no output", cur);
            end else begin
               exp_v = exp_q.pop_front();
               if (cur !== exp_v) begin
                  n_fail++;
                  $display("FAIL out_byte: got {sop,eop,dest,data}=%h, required %h", cur, exp_v);
               end
            end
         end
         prev_hold = (sw.out_valid === 1'b1) && (sw.out_ready === 1'b0);
         prev_out  = cur;
      end
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         sw.out_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic drive_byte(input logic s, input logic [7:0] d);
      sw.status_in = s;
      sw.data_in   = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_byte(1'b0, 8'h00);
   endtask

   task automatic send_pkt(input logic [7:0] hdr, input int len, input logic [7:0] base,
                           input bit push);
      logic [7:0] b;
      drive_byte(1'b1, hdr);
      drive_byte(1'b0, 8'(len));
      for (int i = 0; i < len; i++) begin
         b = base + 8'(i);
         if (push) exp_q.push_back({(i == 0), (i == len - 1), hdr[DEST_W-1:0], b});
         drive_byte(1'b0, b);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sw.out_ready = 1'b0;
      idle(2);
      rst = 1'b0;
      exp_q.delete();
      n_out = 0;
   endtask

   task automatic drain(input string name);
      int guard;
      guard = 0;
      while ((exp_q.size() != 0 || sw.out_valid === 1'b1) && guard < 400) begin
         idle(1);
         guard++;
      end
      n_checks++;
      if (exp_q.size() != 0 || sw.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_drain: got %0d bytes missing, valid=%b, required 0 and 0",
                  name, exp_q.size(), sw.out_valid);
      end
   endtask

   task automatic check8(input string name, input logic [7:0] got, input logic [7:0] req);
      n_checks++;
      if (got !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   task automatic test_reset();
      sw.status_in = 1'b0;
      sw.data_in   = 8'h00;
      do_reset();
      n_checks++;
      if (sw.out_valid !== 1'b0 || sw.busy !== 1'b0 || sw.fsm_state !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_flags: got valid=%b busy=%b state=%0d, required 0 0 0",
                  sw.out_valid, sw.busy, sw.fsm_state);
      end
      check8("reset_pkt_cnt", sw.pkt_cnt, 8'd0);
      check8("reset_drop_cnt", sw.drop_cnt, 8'd0);
   endtask

   task automatic test_basic();
      do_reset();
      sw.out_ready = 1'b1;
      drive_byte(1'b1, 8'h02);
      drive_byte(1'b0, 8'd3);
      exp_q.push_back({1'b1, 1'b0, 2'd2, 8'hA1});
      drive_byte(1'b0, 8'hA1);
      exp_q.push_back({1'b0, 1'b0, 2'd2, 8'hA2});
      drive_byte(1'b0, 8'hA2);
      exp_q.push_back({1'b0, 1'b1, 2'd2, 8'hA3});
      drive_byte(1'b0, 8'hA3);
      n_checks++;
      if (sw.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_early_valid: got %b, required 0", sw.out_valid);
      end
      idle(1);
      n_checks++;
      if (sw.out_valid !== 1'b1 || sw.out_data !== 8'hA1 || sw.out_sop !== 1'b1 ||
          sw.out_dest !== 2'd2) begin
         n_fail++;
         $display("FAIL basic_first_out: got valid=%b data=%h sop=%b dest=%0d, required 1 a1 1 2",
                  sw.out_valid, sw.out_data, sw.out_sop, sw.out_dest);
      end
      check8("basic_pkt_cnt", sw.pkt_cnt, 8'd1);
      drain("basic");
      check8("basic_out_count", 8'(n_out), 8'd3);
   endtask

   task automatic test_zero_len();
      do_reset();
      sw.out_ready = 1'b1;
      drive_byte(1'b1, 8'h01);
      drive_byte(1'b0, 8'd0);
      check8("zero_len_state", {6'd0, sw.fsm_state}, 8'd0);
      check8("zero_len_drop_cnt", sw.drop_cnt, 8'd1);
      idle(4);
      n_checks++;
      if (sw.out_valid !== 1'b0 || n_out != 0) begin
         n_fail++;
         $display("FAIL zero_len_output: got valid=%b outs=%0d, required 0 0", sw.out_valid, n_out);
      end
      check8("zero_len_pkt_cnt", sw.pkt_cnt, 8'd0);
   endtask

   task automatic test_overflow();
      do_reset();
      send_pkt(8'h01, 10, 8'h10, 1'b1);
      n_checks++;
      if (sw.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL overflow_busy1: got %b, required 0", sw.busy);
      end
      send_pkt(8'h02, 10, 8'h40, 1'b0);
      n_checks++;
      if (sw.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL overflow_busy2: got %b, required 0", sw.busy);
      end
      check8("overflow_drop_cnt", sw.drop_cnt, 8'd1);
      check8("overflow_pkt_cnt", sw.pkt_cnt, 8'd1);
      sw.out_ready = 1'b1;
      drain("overflow");
      check8("overflow_out_count", 8'(n_out), 8'd10);
   endtask

   task automatic test_abort();
      do_reset();
      sw.out_ready = 1'b1;
      drive_byte(1'b1, 8'h01);
      drive_byte(1'b0, 8'd5);
      drive_byte(1'b0, 8'h77);
      drive_byte(1'b0, 8'h78);
      send_pkt(8'h03, 4, 8'hC0, 1'b1);
      idle(1);
      check8("abort_drop_cnt", sw.drop_cnt, 8'd1);
      check8("abort_pkt_cnt", sw.pkt_cnt, 8'd1);
      drain("abort");
      check8("abort_out_count", 8'(n_out), 8'd4);
   endtask

   task automatic test_stream();
      int guard;
      do_reset();
      rand_ready = 1'b1;
      for (int p = 0; p < 40; p++) begin
         guard = 0;
         while (exp_q.size() > 8 && guard < 500) begin
            idle(1);
            guard++;
         end
         send_pkt(8'(p % 4), 7, 8'(p * 7), 1'b1);
      end
      rand_ready = 1'b0;
      idle(1);
      sw.out_ready = 1'b1;
      drain("stream");
      check8("stream_pkt_cnt", sw.pkt_cnt, 8'd40);
      check8("stream_drop_cnt", sw.drop_cnt, 8'd0);
      n_checks++;
      if (n_out != 280) begin
         n_fail++;
         $display("FAIL stream_out_count: got %0d, required 280", n_out);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      send_pkt(8'h01, 3, 8'h20, 1'b1);
      idle(1);
      drive_byte(1'b1, 8'h02);
      drive_byte(1'b0, 8'd4);
      drive_byte(1'b0, 8'h30);
      drive_byte(1'b0, 8'h31);
      rst = 1'b1;
      drive_byte(1'b0, 8'h32);
      exp_q.delete();
      n_checks++;
      if (sw.out_valid !== 1'b0 || sw.fsm_state !== 2'd0) begin
         n_fail++;
         $display("FAIL rst_mid_flags: got valid=%b state=%0d, required 0 0",
                  sw.out_valid, sw.fsm_state);
      end
      check8("rst_mid_pkt_cnt", sw.pkt_cnt, 8'd0);
      check8("rst_mid_drop_cnt", sw.drop_cnt, 8'd0);
      rst = 1'b0;
      n_out = 0;
      sw.out_ready = 1'b1;
      send_pkt(8'h00, 2, 8'h55, 1'b1);
      drain("rst_mid");
      check8("rst_mid_pkt_after", sw.pkt_cnt, 8'd1);
      check8("rst_mid_out_count", 8'(n_out), 8'd2);
   endtask

   initial begin
      sw.status_in = 1'b0;
      sw.data_in   = 8'h00;
      sw.out_ready = 1'b0;
      test_reset();
      test_basic();
      test_zero_len();
      test_overflow();
      test_abort();
      test_stream();
      test_reset_mid();
      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/switch_in_port.md
SWITCH_IN_PORT -- requirements
Module: switch_in_port

Interface
REQ-001 Parameter DEPTH, default 16, meaning packet buffer entries; power of 2, minimum 4.
REQ-002 Parameter DEST_W, default 2, meaning destination field width (4 output ports).
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 data_in  input  8  byte from the input port interface, sampled every clk edge.
REQ-006 status_in  input  1  1 = header (address) byte, 0 = length/payload/idle byte.
REQ-007 busy  output  1  1 = buffer full; upstream driver holds off new headers.
REQ-008 out_valid  output  1  committed byte available at output.
REQ-009 out_ready  input  1  downstream accepts byte when out_valid&&out_ready.
REQ-010 out_data  output  8  payload byte.
REQ-011 out_dest  output  DEST_W  destination port of current packet.
REQ-012 out_sop / out_eop  output  1 each  first / last payload byte of packet.
REQ-013 pkt_cnt / drop_cnt  output  8 each  accepted / dropped packet counters.

Function
REQ-014 Packet on input = header byte (status_in=1, dest = data_in[DEST_W-1:0]), then length byte L (status_in=0), then L payload bytes (status_in=0) on consecutive cycles.
REQ-015 FSM states IDLE, LEN, PAYLOAD, DROP; reset state IDLE.
REQ-016 IDLE: status_in=1 -> latch dest, go LEN; status_in=0 -> byte ignored, stay IDLE.
REQ-017 LEN: L=0 or L > free entries (DEPTH minus tentative occupancy) -> drop_cnt+1, go DROP with remaining=L; else remaining=L, go PAYLOAD.
REQ-018 PAYLOAD: each cycle write {sop,eop,dest,data_in} at tentative write pointer; sop on first byte, eop when remaining=1; after eop byte, commit pointer := tentative pointer on next edge, pkt_cnt+1, go IDLE.
REQ-019 DROP: consume bytes without writing, decrement remaining, go IDLE after last; L=0 goes IDLE immediately.
REQ-020 status_in=1 in LEN, PAYLOAD or DROP: abort current packet (tentative pointer rewinds to commit pointer, drop_cnt+1 unless already counted in DROP), treat byte as new header, go LEN.
REQ-021 Output side sees committed entries only; out_valid = (read pointer != commit pointer); out_* fields driven from entry at read pointer.
REQ-022 Read pointer advances on out_valid&&out_ready; never passes commit pointer.
REQ-023 Latency: last payload byte sampled at edge N -> out_valid may assert after edge N+1 (commit); never earlier.
REQ-024 Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full = MSBs differ, lower bits equal.
REQ-025 busy = tentative occupancy == DEPTH (combinational from registers).
REQ-026 Simultaneous read and write in same cycle permitted; free space in REQ-017 uses read pointer value before that edge.
REQ-027 pkt_cnt and drop_cnt saturate at 255.
REQ-028 Outputs hold stable while out_valid=1 and out_ready=0.

Reset
REQ-029 rst=1 at an edge: state IDLE, all pointers 0, counters 0, out_valid=0, busy=0; buffer contents need not clear.
REQ-030 rst mid-packet discards tentative and committed data; first cycle after rst release samples data_in normally.

Verification
REQ-031 Header 0x02, L=3, payload 0xA1,0xA2,0xA3, out_ready=1 -> three outputs dest=2, sop on 0xA1, eop on 0xA3, out_valid first high 1 cycle after 0xA3 sampled, pkt_cnt=1.
REQ-032 L=0 after header -> no output, drop_cnt=1, FSM IDLE next cycle.
REQ-033 DEPTH=16, out_ready=0, send L=10 then L=10 -> first committed, second dropped (free=6), drop_cnt=1; busy=0 throughout.
REQ-034 Header inside payload after 2 of L=5 bytes -> first packet discarded, nothing output from it, new packet proceeds normally, drop_cnt=1.
REQ-035 Stream 40 packets L=7 with out_ready toggled randomly -> pointer wrap exercised, all 280 bytes out in order, no loss, pkt_cnt=40.
REQ-036 rst asserted mid-PAYLOAD with one committed packet pending -> out_valid=0, counters 0 next cycle; subsequent packet delivered correctly.
